// File: rtl/ahb3lite_mem_slave_if.sv
// ahb3lite_mem_slave_if: AHB-Lite bus signals between a master and the memory responder.
interface ahb3lite_mem_slave_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [2:0]  HBURST;
   logic [1:0]  HTRANS;
   logic [31:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [31:0] HRDATA;
   modport master (
      output HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
      input  HREADYOUT, HRESP, HRDATA
   );
   modport slave (
      input  HSEL, HADDR, HWRITE, HSIZE, HBURST, HTRANS, HWDATA, HREADY,
      output HREADYOUT, HRESP, HRDATA
   );
endinterface

// File: rtl/ahb3lite_mem_slave.sv
// ahb3lite_mem_slave: AHB-Lite word memory responder with programmable wait states and two-cycle ERROR.
module ahb3lite_mem_slave #(
   parameter logic [31:0] BASE  = 32'h0000_0000,
   parameter int          DEPTH = 64,
   parameter int          AW    = $clog2(DEPTH)
) (
   input  logic                 HCLK,
   input  logic                 HRESET,
   ahb3lite_mem_slave_if.slave  bus,
   input  logic [3:0]           i_wait_cycles,
   input  logic [AW-1:0]        i_dbg_addr,
   output logic [31:0]          o_dbg_data,
   output logic [15:0]          o_wr_count,
   output logic [15:0]          o_err_count
);
   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
   state_e        state_q;
   logic          ready_q;
   logic          resp_q;
   logic          wr_q;
   logic [3:0]    cnt_q;
   logic [AW-1:0] idx_q;
   logic [15:0]   wr_cnt_q;
   logic [15:0]   err_cnt_q;
   logic [31:0]   mem_q [DEPTH];
   logic [31:0]   off;
   logic          accept;
   logic          illegal;
   assign off     = bus.HADDR - BASE;
   assign accept  = bus.HSEL && bus.HREADY && bus.HTRANS[1];
   assign illegal = (off >= 32'(DEPTH)) || (bus.HSIZE != 3'b010);
   assign bus.HREADYOUT = ready_q;
   assign bus.HRESP     = resp_q;
   assign bus.HRDATA    = (state_q == S_DATA && !wr_q) ? mem_q[idx_q] : '0;
   assign o_dbg_data    = mem_q[i_dbg_addr];
   assign o_wr_count    = wr_cnt_q;
   assign o_err_count   = err_cnt_q;
   // Ready states (IDLE/DATA/ERR2) double as the address phase of the next transfer.
   always_ff @(posedge HCLK or posedge HRESET)
      if (HRESET) begin
         state_q   <= S_IDLE;
         ready_q   <= 1'b1;
         resp_q    <= 1'b0;
         wr_q      <= 1'b0;
         cnt_q     <= '0;
         idx_q     <= '0;
         wr_cnt_q  <= '0;
         err_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (state_q == S_DATA && wr_q) begin
            mem_q[idx_q] <= bus.HWDATA;
            wr_cnt_q     <= wr_cnt_q + 16'd1;
         end
         if (state_q == S_ERR2) err_cnt_q <= err_cnt_q + 16'd1;
         case (state_q)
            S_WAIT:
               if (cnt_q == 4'd1) begin
                  state_q <= S_DATA;
                  ready_q <= 1'b1;
               end else cnt_q <= cnt_q - 4'd1;
            S_ERR1: begin
               state_q <= S_ERR2;
               ready_q <= 1'b1;
            end
            default:
               if (accept) begin
                  idx_q <= off[AW-1:0];
                  wr_q  <= bus.HWRITE;
                  cnt_q <= i_wait_cycles;
                  if (illegal) begin
                     state_q <= S_ERR1;
                     ready_q <= 1'b0;
                     resp_q  <= 1'b1;
                  end else begin
                     state_q <= (i_wait_cycles == 4'd0) ? S_DATA : S_WAIT;
                     ready_q <= (i_wait_cycles == 4'd0);
                     resp_q  <= 1'b0;
                  end
               end else begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  resp_q  <= 1'b0;
               end
         endcase
      end
endmodule
